adrv9001_axis_capture: RTL and testbench

Parametrised, self-contained capture engine for an ADRV9001 AXI-Stream data path, replacing the free-running probe arrangement with an armed, triggered circular buffer. It snoops a monitored stream (tvalid & tready beats), holds a programmable number of pre-trigger samples, triggers on enable edges or a masked DGPIO pattern, and replays the capture on an AXI-Stream master for readout by the PS/DMA. All inputs are already synchronised to `clk` upstream; this block contains no CDC.

---
 rtl/adrv9001_capture_pkg.sv | 18 +
 rtl/adrv9001_capture_ram.sv | 27 ++
 rtl/adrv9001_axis_capture.sv | 207 ++++++++++++++++++++
 tb/tb_adrv9001_axis_capture.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_capture_pkg.sv
// adrv9001_capture_pkg: shared state and trigger-mode encodings
// for the ADRV9001 AXI-Stream capture engine.
package adrv9001_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } cap_state_t;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_EN_RISE   = 2'd1;
    localparam logic [1:0] TRIG_EN_FALL   = 2'd2;
    localparam logic [1:0] TRIG_DGPIO     = 2'd3;

endpackage

// File: rtl/adrv9001_capture_ram.sv
// adrv9001_capture_ram: simple dual-port sample buffer, one write
// port and one registered read port (BRAM-inferable).
module adrv9001_capture_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adrv9001_axis_capture.sv
// adrv9001_axis_capture: armed, triggered circular capture of a monitored
// AXI-Stream with pre-trigger history and AXIS master replay.
module adrv9001_axis_capture
    import adrv9001_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int GPIO_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [GPIO_WIDTH-1:0] trig_mask,
    input  logic [GPIO_WIDTH-1:0] trig_value,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic                  adrv9001_enable,
    input  logic [GPIO_WIDTH-1:0] dgpio,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_ptr
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    cap_state_t st_q, st_d;

    logic                  en_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, pre_len;
    logic [CW-1:0]         cnt, cnt_inc, post_len, rd_left;
    logic                  sample, wr_en, arm_ok;
    logic                  trig_hit, trig_fire, fill_full, post_full;
    logic                  rd_issue, pop;
    logic [1:0]            held;
    logic [DATA_WIDTH-1:0] ram_q, skid_data;
    logic                  ram_vld, ram_last, skid_valid, skid_last;

    assign state  = st_q;
    assign sample = s_axis_tvalid & s_axis_tready;
    assign arm_ok = arm & ~abort & (st_q == ST_IDLE);
    assign wr_en  = sample & ~abort
                  & (st_q inside {ST_FILL, ST_ARMED, ST_POST});

    // The trigger cycle restarts the count, so ARMED counts from zero.
    assign cnt_inc   = ((st_q == ST_ARMED) ? '0 : cnt) + CW'(1);
    assign post_len  = DEPTH - {1'b0, pre_len};
    assign fill_full = sample & (cnt_inc == {1'b0, pre_len});
    assign post_full = sample & (cnt_inc == post_len);
    assign trig_fire = (st_q == ST_ARMED) & trig_hit & ~abort;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TRIG_IMMEDIATE: trig_hit = 1'b1;
            TRIG_EN_RISE:   trig_hit = adrv9001_enable & ~en_q;
            TRIG_EN_FALL:   trig_hit = ~adrv9001_enable & en_q;
            default:        trig_hit = (dgpio & trig_mask)
                                    == (trig_value & trig_mask);
        endcase
    end

    always_comb begin
        st_d = st_q;
        if (abort) begin
            st_d = ST_IDLE;
        end else begin
            unique case (st_q)
                ST_IDLE: if (arm)
                    st_d = (pretrig_len == '0) ? ST_ARMED : ST_FILL;
                ST_FILL: if (fill_full)
                    st_d = ST_ARMED;
                ST_ARMED: if (trig_hit)
                    st_d = post_full ? ST_READ : ST_POST;
                ST_POST: if (post_full)
                    st_d = ST_READ;
                ST_READ: if (pop && m_axis_tlast)
                    st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pre_len   <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            trig_ptr  <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            en_q <= adrv9001_enable;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (arm_ok) begin
                pre_len   <= pretrig_len;
                triggered <= 1'b0;
                done      <= 1'b0;
            end
            if (arm_ok) begin
                cnt <= '0;
            end else if (wr_en) begin
                cnt <= cnt_inc;
            end else if (trig_fire) begin
                cnt <= '0;
            end
            if (trig_fire) begin
                trig_ptr  <= wr_ptr;
                rd_ptr    <= wr_ptr - pre_len;
                rd_left   <= DEPTH;
                triggered <= 1'b1;
            end
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                rd_left <= rd_left - CW'(1);
            end
            if (st_q == ST_READ && pop && m_axis_tlast && !abort) begin
                done <= 1'b1;
            end
        end
    end

    adrv9001_capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(s_axis_tdata),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr),
        .rd_data(ram_q)
    );

    // Reads are issued only when the output + skid pair can absorb them.
    assign pop  = m_axis_tvalid & m_axis_tready;
    assign held = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(ram_vld);
    assign rd_issue = (st_q == ST_READ) & ~abort & (rd_left != '0)
                    & ((held < 2'd2) | ((held == 2'd2) & pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
            ram_vld       <= 1'b0;
            ram_last      <= 1'b0;
        end else if (abort) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
            ram_vld       <= 1'b0;
            ram_last      <= 1'b0;
        end else begin
            ram_vld  <= rd_issue;
            ram_last <= rd_issue & (rd_left == CW'(1));
            if (!m_axis_tvalid || pop) begin
                if (skid_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tlast  <= skid_last;
                    skid_valid    <= ram_vld;
                    skid_data     <= ram_q;
                    skid_last     <= ram_last;
                end else begin
                    m_axis_tvalid <= ram_vld;
                    m_axis_tlast  <= ram_vld & ram_last;
                    if (ram_vld) begin
                        m_axis_tdata <= ram_q;
                    end
                end
            end else if (ram_vld) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= ram_last;
            end
        end
    end

endmodule

// File: tb/tb_adrv9001_axis_capture.sv
// tb_adrv9001_axis_capture: randomized capture scenarios scored against
// a queue-based reference of the capture rules.
module tb_adrv9001_axis_capture;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int GW = 12;
    localparam int DEPTH = 16;

    typedef enum int {
        P_IDLE = 0, P_FILL = 1, P_ARMED = 2, P_POST = 3, P_READ = 4
    } ph_t;

    logic          clk = 1'b0;
    logic          rst, arm, abort;
    logic [1:0]    trig_mode;
    logic [GW-1:0] trig_mask, trig_value, dgpio;
    logic [AW-1:0] pretrig_len;
    logic          adrv9001_enable;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [2:0]    state;
    logic          triggered, done;
    logic [AW-1:0] trig_ptr;

    adrv9001_axis_capture #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GPIO_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_mask(trig_mask),
        .trig_value(trig_value), .pretrig_len(pretrig_len),
        .adrv9001_enable(adrv9001_enable), .dgpio(dgpio),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .state(state),
        .triggered(triggered), .done(done), .trig_ptr(trig_ptr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Source/sink policies: 0 always, 1 gapped or toggling, 2 random, 3 off
    int vpol = 3;
    int rpol = 0;
    int ramp = 0;
    int gap = 0;
    bit tog = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) ramp = 0;
        else if (s_axis_tvalid && s_axis_tready) ramp++;
        s_axis_tdata = DW'(ramp);
        gap = (gap + 1) % 3;
        tog = ~tog;
        case (vpol)
            0: begin s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; end
            1: begin s_axis_tvalid = (gap == 0); s_axis_tready = 1'b1; end
            2: begin
                s_axis_tvalid = ($urandom_range(0, 2) != 0);
                s_axis_tready = ($urandom_range(0, 4) != 0);
            end
            default: begin s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; end
        endcase
        case (rpol)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = tog;
            default: m_axis_tready = ($urandom_range(0, 9) != 0);
        endcase
    end

    // Reference model and monitor
    ph_t         mph = P_IDLE;
    bit          mdl_ok = 1'b0;
    bit          en_prev, exp_trg, exp_done;
    int          exp_tp, pre, hist_start, trig_idx;
    logic [DW-1:0] hist[$];
    logic [DW-1:0] expq[$];
    bit          stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic        stall_last;
    int          beats = 0;
    logic [DW-1:0] rx[DEPTH];

    function automatic void post_check();
        if (hist.size() - trig_idx == DEPTH - pre) begin
            for (int i = 0; i < DEPTH; i++)
                expq.push_back(hist[trig_idx - pre + i]);
            mph = P_READ;
        end
    endfunction

    always @(negedge clk) begin
        logic hs, last_hs, smp, fire;
        last_hs = 1'b0;
        if (mdl_ok) begin
            chk("state", 64'(state), 64'(int'(mph)));
            chk("triggered", 64'(triggered), 64'(exp_trg));
            chk("done", 64'(done), 64'(exp_done));
            chk("trig_ptr", 64'(trig_ptr), 64'(exp_tp));
            if (mph != P_READ) chk("idle_tvalid", 64'(m_axis_tvalid), 0);
            if (stall_prev) begin
                chk("stall_valid", 64'(m_axis_tvalid), 1);
                chk("stall_data", 64'(m_axis_tdata), 64'(stall_data));
                chk("stall_last", 64'(m_axis_tlast), 64'(stall_last));
            end
        end
        hs = m_axis_tvalid && m_axis_tready;
        stall_prev = m_axis_tvalid && !m_axis_tready && !abort && !rst;
        stall_data = m_axis_tdata;
        stall_last = m_axis_tlast;
        if (mdl_ok && hs && !rst) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_unexpected: got %0h expected none",
                         m_axis_tdata);
            end else begin
                chk("beat_data", 64'(m_axis_tdata), 64'(expq[0]));
                chk("beat_last", 64'(m_axis_tlast), 64'(expq.size() == 1));
                last_hs = (expq.size() == 1);
                void'(expq.pop_front());
            end
            if (beats < DEPTH) rx[beats] = m_axis_tdata;
            beats++;
        end
        if (rst) begin
            mph = P_IDLE;
            en_prev = 1'b0;
            hist.delete();
            expq.delete();
            exp_trg = 1'b0;
            exp_done = 1'b0;
            exp_tp = 0;
            stall_prev = 1'b0;
            mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            smp = s_axis_tvalid && s_axis_tready;
            if (abort) begin
                mph = P_IDLE;
                expq.delete();
            end else begin
                case (mph)
                    P_IDLE: if (arm) begin
                        pre = int'(pretrig_len);
                        exp_trg = 1'b0;
                        exp_done = 1'b0;
                        hist_start = hist.size();
                        mph = (pre == 0) ? P_ARMED : P_FILL;
                    end
                    P_FILL: if (smp) begin
                        hist.push_back(s_axis_tdata);
                        if (hist.size() - hist_start == pre) mph = P_ARMED;
                    end
                    P_ARMED: begin
                        case (trig_mode)
                            2'd0: fire = 1'b1;
                            2'd1: fire = adrv9001_enable && !en_prev;
                            2'd2: fire = !adrv9001_enable && en_prev;
                            default: fire = ((dgpio & trig_mask)
                                          == (trig_value & trig_mask));
                        endcase
                        if (fire) begin
                            trig_idx = hist.size();
                            exp_tp = trig_idx % DEPTH;
                            exp_trg = 1'b1;
                            mph = P_POST;
                        end
                        if (smp) hist.push_back(s_axis_tdata);
                        if (fire) post_check();
                    end
                    P_POST: if (smp) begin
                        hist.push_back(s_axis_tdata);
                        post_check();
                    end
                    default: if (last_hs) begin
                        mph = P_IDLE;
                        exp_done = 1'b1;
                    end
                endcase
            end
            en_prev = adrv9001_enable;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_cap(input logic [1:0] mode, input int pl,
                           input int vp, input int rp);
        trig_mode = mode;
        pretrig_len = AW'(pl);
        vpol = vp;
        rpol = rp;
        beats = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_done"}, 64'(done), 1);
        chk({nm, "_beats"}, 64'(beats), DEPTH);
    endtask

    initial begin
        int n;
        int tsmp;
        rst = 1'b1; arm = 1'b0; abort = 1'b0;
        trig_mode = 2'd0; trig_mask = '0; trig_value = '0; dgpio = '0;
        pretrig_len = '0; adrv9001_enable = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tready = 1'b1;
        m_axis_tready = 1'b1;
        step(3);
        rst = 1'b0;
        chk("rst_state", 64'(state), 0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 0);
        chk("rst_tlast", 64'(m_axis_tlast), 0);
        chk("rst_tdata", 64'(m_axis_tdata), 0);
        chk("rst_triggered", 64'(triggered), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_trig_ptr", 64'(trig_ptr), 0);

        // Immediate trigger on a fresh ramp: frame is exactly 0..15
        run_cap(2'd0, 4, 0, 0);
        wait_done("t1", 200);
        for (int i = 0; i < DEPTH; i++) chk("t1_ramp", 64'(rx[i]), 64'(i));

        // Enable rising edge on sample 40
        vpol = 3;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        run_cap(2'd1, 5, 0, 0);
        n = 0;
        while (ramp != 40 && n < 200) begin step(); n++; end
        adrv9001_enable = 1'b1;
        step();
        wait_done("t2", 200);
        adrv9001_enable = 1'b0;
        chk("t2_trig_ptr", 64'(trig_ptr), 8);
        chk("t2_first", 64'(rx[0]), 35);
        chk("t2_trig_beat", 64'(rx[5]), 40);
        chk("t2_last", 64'(rx[15]), 50);

        // DGPIO match during FILL is ignored; only the ARMED match counts
        trig_mask = 12'h00F;
        trig_value = 12'h005;
        dgpio = 12'h0A5;
        run_cap(2'd3, 8, 0, 0);
        step(3);
        dgpio = 12'h000;
        n = 0;
        while (state != 3'd2 && n < 100) begin step(); n++; end
        step(3);
        chk("t3_not_trig", 64'(triggered), 0);
        dgpio = 12'h0A5;
        tsmp = ramp;
        step();
        dgpio = 12'h000;
        wait_done("t3", 200);
        chk("t3_trig_beat", 64'(rx[8]), 64'(tsmp));

        // Readout back-pressure: toggling, then random ready
        run_cap(2'd0, 3, 0, 1);
        wait_done("t4a", 400);
        run_cap(2'd0, 7, 2, 2);
        wait_done("t4b", 800);

        // Gapped source 1-in-3
        run_cap(2'd0, 6, 1, 0);
        wait_done("t5", 800);

        // Abort mid-READ, then a fresh capture
        run_cap(2'd0, 2, 0, 0);
        n = 0;
        while (beats < 7 && n < 200) begin step(); n++; end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_abort_tvalid", 64'(m_axis_tvalid), 0);
        chk("t6_abort_state", 64'(state), 0);
        run_cap(2'd0, 9, 0, 2);
        wait_done("t6", 400);

        // Boundary pretrigger lengths with random traffic
        for (int k = 0; k < 6; k++) begin
            int pl;
            pl = (k == 0) ? 0 : (k == 1) ? DEPTH - 1 : $urandom_range(0, 15);
            run_cap(2'd0, pl, $urandom_range(0, 2), $urandom_range(0, 2));
            wait_done("rnd", 1000);
        end

        // Reset during POST
        run_cap(2'd1, 2, 0, 0);
        step(6);
        adrv9001_enable = 1'b1;
        step();
        adrv9001_enable = 1'b0;
        chk("t7_post", 64'(state), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_state", 64'(state), 0);
        chk("t7_tvalid", 64'(m_axis_tvalid), 0);
        chk("t7_tlast", 64'(m_axis_tlast), 0);
        chk("t7_tdata", 64'(m_axis_tdata), 0);
        chk("t7_triggered", 64'(triggered), 0);
        chk("t7_done", 64'(done), 0);
        chk("t7_trig_ptr", 64'(trig_ptr), 0);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
